// File: rtl/rx_ltssm_pkg.sv
// Shared types for the RX LTSSM substate evaluator: substate codes,
// evaluator FSM states and the per-substate requirement table.
package rx_ltssm_pkg;

    typedef enum logic [3:0] {
        DETECT_QUIET   = 4'd0,
        DETECT_ACTIVE  = 4'd1,
        POLLING_ACTIVE = 4'd2,
        POLLING_CONFIG = 4'd3,
        CFG_LW_START   = 4'd4,
        CFG_LW_ACCEPT  = 4'd5,
        CFG_LN_WAIT    = 4'd6,
        CFG_LN_ACCEPT  = 4'd7,
        CFG_COMPLETE   = 4'd8,
        CFG_IDLE       = 4'd9,
        L0             = 4'd10
    } substate_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DONE
    } state_e;

    localparam int UNITS_W = 6;

    typedef struct packed {
        logic               valid;
        logic [4:0]         os_req;
        logic [UNITS_W-1:0] units;
        logic [3:0]         pass_exit;
        logic [3:0]         fail_exit;
    } sub_cfg_t;

    // Codes without an entry come back invalid, which the FSM turns
    // into an immediate fail towards DETECT_QUIET.
    function automatic sub_cfg_t sub_table(input logic [3:0] code);
        sub_cfg_t c;
        c = '0;
        case (code)
            DETECT_QUIET:
                c = '{1'b1, 5'd0, 6'd12, DETECT_ACTIVE, DETECT_ACTIVE};
            DETECT_ACTIVE:
                c = '{1'b1, 5'd0, 6'd0, POLLING_ACTIVE, DETECT_QUIET};
            POLLING_ACTIVE:
                c = '{1'b1, 5'd8, 6'd24, POLLING_CONFIG, DETECT_QUIET};
            POLLING_CONFIG:
                c = '{1'b1, 5'd8, 6'd48, CFG_LW_START, DETECT_QUIET};
            CFG_LW_START:
                c = '{1'b1, 5'd2, 6'd24, CFG_LW_ACCEPT, DETECT_QUIET};
            CFG_LW_ACCEPT:
                c = '{1'b1, 5'd2, 6'd24, CFG_LN_WAIT, DETECT_QUIET};
            CFG_LN_WAIT:
                c = '{1'b1, 5'd2, 6'd2, CFG_LN_ACCEPT, DETECT_QUIET};
            CFG_LN_ACCEPT:
                c = '{1'b1, 5'd2, 6'd24, CFG_COMPLETE, DETECT_QUIET};
            CFG_COMPLETE:
                c = '{1'b1, 5'd8, 6'd24, CFG_IDLE, DETECT_QUIET};
            CFG_IDLE:
                c = '{1'b1, 5'd8, 6'd2, L0, DETECT_QUIET};
            default:
                c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rx_ltssm_timeout_timer.sv
// Substate timeout timer: UNIT_CYCLES prescaler feeding a saturating
// unit counter. Ports: clk, reset, clear_i, enable_i, units_i, expired_o.
module rx_ltssm_timeout_timer
    import rx_ltssm_pkg::*;
#(
    parameter int UNIT_CYCLES = 1000,
    parameter int TIMER_W     = 24
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [UNITS_W-1:0] units_i,
    output logic               expired_o
);

    logic [TIMER_W-1:0] pre_q;
    logic [UNITS_W-1:0] unit_q;
    logic               last_pre;

    assign last_pre = (pre_q == TIMER_W'(UNIT_CYCLES - 1));

    // Asserted during the cycle that completes units_i*UNIT_CYCLES
    // enabled cycles; zero units means no timeout at all.
    assign expired_o = (units_i != '0) &&
                       (({1'b0, unit_q} + {{UNITS_W{1'b0}}, last_pre})
                        >= {1'b0, units_i});

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            pre_q  <= '0;
            unit_q <= '0;
        end else if (enable_i) begin
            if (last_pre) begin
                pre_q <= '0;
                if (unit_q != '1) begin
                    unit_q <= unit_q + 1'b1;
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_ltssm_substate_ctrl.sv
// RX LTSSM substate evaluator: arms lane checkers, waits for all active
// lanes or timeout, reports pass/fail and next substate.
// Ports: clk/reset, req/substate/num_lanes, os_hit, rx_elec_idle, abort;
// busy, done, pass, exit_to, os_required, os_chk_rst, lane_mask,
// disable_descrambler.
module rx_ltssm_substate_ctrl
    import rx_ltssm_pkg::*;
#(
    parameter int MAXLANES    = 16,
    parameter int UNIT_CYCLES = 1000,
    parameter int TIMER_W     = 24
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic [3:0]                substate,
    input  logic [$clog2(MAXLANES):0] num_lanes,
    input  logic [MAXLANES-1:0]       os_hit,
    input  logic                      rx_elec_idle,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [3:0]                exit_to,
    output logic [4:0]                os_required,
    output logic [MAXLANES-1:0]       os_chk_rst,
    output logic [MAXLANES-1:0]       lane_mask,
    output logic                      disable_descrambler
);

    localparam int LW = $clog2(MAXLANES) + 1;

    state_e              state_q, state_d;
    logic [3:0]          sub_q, sub_d;
    logic [MAXLANES-1:0] mask_q, mask_d;
    sub_cfg_t            cfg_q, cfg_d;
    logic                pass_q, pass_d;
    logic [3:0]          exit_q, exit_d;

    logic [MAXLANES-1:0] mask_calc;
    logic                tmr_clr;
    logic                tmr_en;
    logic                expired;
    logic                ok;

    // Thermometer mask; out-of-range counts give no lanes.
    always_comb begin
        mask_calc = '0;
        for (int i = 0; i < MAXLANES; i++) begin
            mask_calc[i] = (num_lanes <= LW'(MAXLANES)) &&
                           (LW'(i) < num_lanes);
        end
    end

    always_comb begin
        ok = 1'b0;
        if (sub_q == DETECT_QUIET) begin
            ok = !rx_elec_idle;
        end else if (cfg_q.os_req == '0) begin
            ok = 1'b1;
        end else begin
            ok = (mask_q != '0) && ((os_hit & mask_q) == mask_q);
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        mask_d  = mask_q;
        cfg_d   = cfg_q;
        pass_d  = pass_q;
        exit_d  = exit_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sub_d   = substate;
                    mask_d  = mask_calc;
                    cfg_d   = sub_table(substate);
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                tmr_clr = 1'b1;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                tmr_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!cfg_q.valid || expired) begin
                    pass_d  = 1'b0;
                    exit_d  = cfg_q.fail_exit;
                    state_d = ST_DONE;
                end else if (ok) begin
                    pass_d  = 1'b1;
                    exit_d  = cfg_q.pass_exit;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sub_q   <= '0;
            mask_q  <= '0;
            cfg_q   <= '0;
            pass_q  <= 1'b0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            mask_q  <= mask_d;
            cfg_q   <= cfg_d;
            pass_q  <= pass_d;
            exit_q  <= exit_d;
        end
    end

    rx_ltssm_timeout_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .units_i   (cfg_q.units),
        .expired_o (expired)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign exit_to     = exit_q;
    assign os_required = cfg_q.os_req;
    assign lane_mask   = mask_q;
    // Unused lanes stay in reset while counting.
    assign os_chk_rst  = (state_q == ST_COUNT) ? ~mask_q : '1;
    assign disable_descrambler = busy && (sub_q < 4'd4);

endmodule

// File: tb/tb_rx_ltssm_substate_ctrl.sv
// Self-checking bench for rx_ltssm_substate_ctrl: directed scenarios
// plus randomized traffic against a cycle-timed behavioural model.
module tb_rx_ltssm_substate_ctrl;

    localparam int ML = 16;
    localparam int UC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  substate = '0;
    logic [4:0]  num_lanes = '0;
    logic [15:0] os_hit = '0;
    logic        rx_elec_idle = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, pass, disable_descrambler;
    logic [3:0]  exit_to;
    logic [4:0]  os_required;
    logic [15:0] os_chk_rst, lane_mask;

    rx_ltssm_substate_ctrl #(
        .MAXLANES    (ML),
        .UNIT_CYCLES (UC),
        .TIMER_W     (24)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .substate            (substate),
        .num_lanes           (num_lanes),
        .os_hit              (os_hit),
        .rx_elec_idle        (rx_elec_idle),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .exit_to             (exit_to),
        .os_required         (os_required),
        .os_chk_rst          (os_chk_rst),
        .lane_mask           (lane_mask),
        .disable_descrambler (disable_descrambler)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    bit mstarted = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        vec++;
        if (a !== e) begin
            miss++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, a, e);
        end
    endtask

    // Requirement table straight from the substate list.
    int tab_os[10]    = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 8};
    int tab_units[10] = '{12, 0, 24, 48, 24, 24, 2, 24, 24, 2};

    function automatic logic [15:0] mk(input int n);
        if (n >= 1 && n <= ML) return 16'((32'd1 << n) - 1);
        return 16'h0;
    endfunction

    // Model: an evaluation accepted in cycle t0 counts from cycle t0+2;
    // COUNT cycle k=n-t0-1 decides, done lands one cycle later.
    bit          m_act = 0;
    bit          m_fin = 0;
    int          m_t0 = 0;
    int          m_sub = 0;
    logic [15:0] m_mask = '0;
    bit          e_done = 0;
    bit          e_pass = 0;
    int          e_exit = 0;

    task automatic model_step(input int n);
        int k;
        bit ok;
        bit fl;
        if (reset) begin
            m_act = 0; m_fin = 0; e_done = 0; e_pass = 0; e_exit = 0;
        end else begin
            e_done = 0;
            if (m_fin) begin
                m_act = 0;
                m_fin = 0;
            end else if (!m_act) begin
                if (req) begin
                    m_act = 1; m_t0 = n; m_sub = int'(substate);
                    m_mask = mk(int'(num_lanes));
                end
            end else if (n >= m_t0 + 2) begin
                k = n - m_t0 - 1;
                if (abort) begin
                    m_act = 0;
                end else begin
                    if (m_sub >= 10) fl = 1;
                    else fl = tab_units[m_sub] > 0 &&
                              k >= tab_units[m_sub] * UC;
                    if (m_sub == 0) ok = !rx_elec_idle;
                    else if (m_sub < 10 && tab_os[m_sub] == 0) ok = 1;
                    else ok = (m_mask != 0) &&
                              ((os_hit & m_mask) == m_mask);
                    if (fl) begin
                        m_fin = 1; e_done = 1; e_pass = 0;
                        e_exit = (m_sub == 0) ? 1 : 0;
                    end else if (ok) begin
                        m_fin = 1; e_done = 1; e_pass = 1;
                        e_exit = m_sub + 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(cyc);
        cyc = cyc + 1;
        mstarted = 1;
    end

    always @(negedge clk) begin
        logic [15:0] e_chk;
        if (mstarted) begin
            e_chk = (m_act && !m_fin && cyc >= m_t0 + 2) ? ~m_mask
                                                         : 16'hFFFF;
            chk("busy", busy, m_act);
            chk("done", done, e_done);
            chk("exit_to", exit_to, e_exit);
            chk("os_chk_rst", os_chk_rst, e_chk);
            chk("disable_descrambler", disable_descrambler,
                m_act && m_sub < 4);
            if (m_act) begin
                chk("lane_mask", lane_mask, m_mask);
                chk("os_required", os_required,
                    m_sub < 10 ? tab_os[m_sub] : 0);
            end
            if (e_done) chk("pass", pass, e_pass);
        end
    end

    int t_req;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input int s, input int n);
        step();
        req = 1'b1;
        substate = 4'(s);
        num_lanes = 5'(n);
        t_req = cyc;
        step();
        req = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) begin
            vec++;
            miss++;
            $display("FAIL wait_done cycle %0d: no done within %0d",
                     cyc, bound);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) step();
        step();
    endtask

    initial begin
        int at;
        int cnt;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_exit", exit_to, 0);
        chk("rst_osreq", os_required, 0);
        chk("rst_chkrst", os_chk_rst, 16'hFFFF);
        chk("rst_mask", lane_mask, 0);
        chk("rst_dis", disable_descrambler, 0);
        reset = 1'b0;
        step();

        // Polling.Active, 4 lanes hit in the 2nd COUNT cycle.
        send(2, 4);
        chk("t1_osreq", os_required, 8);
        chk("t1_mask", lane_mask, 16'h000F);
        step();
        chk("t1_chkrst", os_chk_rst, 16'hFFF0);
        step();
        os_hit = 16'h000F;
        wait_done(10, at);
        chk("t1_lat", at - t_req, 4);
        chk("t1_pass", pass, 1);
        chk("t1_exit", exit_to, 3);
        os_hit = '0;
        wait_idle();

        // Lane 2 never hits: 24 units x 10 cycles.
        os_hit = 16'h0003;
        send(4, 3);
        wait_done(300, at);
        chk("t2_lat", at - t_req, 242);
        chk("t2_pass", pass, 0);
        chk("t2_exit", exit_to, 0);
        wait_idle();

        // Detect.Quiet held in electrical idle, then idle drops.
        rx_elec_idle = 1'b1;
        send(0, 4);
        wait_done(200, at);
        chk("t3_lat", at - t_req, 122);
        chk("t3_pass", pass, 0);
        chk("t3_exit", exit_to, 1);
        wait_idle();
        send(0, 4);
        repeat (5) step();
        rx_elec_idle = 1'b0;
        wait_done(20, at);
        chk("t3b_lat", at - t_req, 7);
        chk("t3b_pass", pass, 1);
        chk("t3b_exit", exit_to, 1);
        wait_idle();

        // Hits coincide with the timeout cycle.
        os_hit = '0;
        send(6, 2);
        repeat (20) step();
        os_hit = 16'h0003;
        wait_done(10, at);
        chk("t4_lat", at - t_req, 22);
        chk("t4_pass", pass, 0);
        os_hit = '0;
        wait_idle();

        // Minimum latency, then abort keeps exit_to.
        send(1, 4);
        wait_done(10, at);
        chk("t5_lat", at - t_req, 3);
        chk("t5_exit", exit_to, 2);
        wait_idle();
        send(2, 4);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_exit", exit_to, 2);
        repeat (5) step();

        // Illegal code, zero lanes.
        send(12, 4);
        wait_done(10, at);
        chk("t6_lat", at - t_req, 3);
        chk("t6_pass", pass, 0);
        chk("t6_exit", exit_to, 0);
        wait_idle();
        os_hit = 16'hFFFF;
        send(8, 0);
        wait_done(300, at);
        chk("t6b_lat", at - t_req, 242);
        chk("t6b_pass", pass, 0);
        os_hit = '0;
        wait_idle();

        // Reset in the middle of COUNT.
        send(1, 4);
        wait_done(10, at);
        wait_idle();
        send(3, 4);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_pass", pass, 0);
        chk("t7_exit", exit_to, 0);
        chk("t7_osreq", os_required, 0);
        chk("t7_mask", lane_mask, 0);
        chk("t7_chkrst", os_chk_rst, 16'hFFFF);
        chk("t7_dis", disable_descrambler, 0);

        // Second req while busy is dropped.
        step();
        req = 1'b1; substate = 4'd1; num_lanes = 5'd4;
        step();
        substate = 4'd2;
        step();
        req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) cnt++;
            step();
        end
        chk("t8_dones", cnt, 1);
        chk("t8_exit", exit_to, 2);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            step();
            req = ($urandom_range(0, 5) == 0);
            substate = 4'($urandom_range(0, 12));
            num_lanes = 5'($urandom_range(0, 18));
            case ($urandom_range(0, 3))
                0: os_hit = 16'hFFFF;
                1: os_hit = 16'($urandom);
                default: os_hit = 16'($urandom) & 16'($urandom);
            endcase
            rx_elec_idle = ($urandom_range(0, 7) != 0);
            abort = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        step();
        req = 1'b0; abort = 1'b0; reset = 1'b0;
        repeat (10) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/rx_ltssm_substate_ctrl.md
# rx_ltssm_substate_ctrl

Parametrised RX-side substate evaluator for the PCIe LTSSM. It takes one evaluation request per substate from the main LTSSM and arms the per-lane ordered-set checkers with the required OS count. It then waits until every active lane qualifies or the substate timeout expires, and returns pass/fail with the next substate. Lane count, lane-width mask and timeout scaling are parametrised, and a dedicated internal timer replaces the external timer handshake.

## Interface
- MAXLANES, 16, number of physical lanes; 1..32
- UNIT_CYCLES, 1000, clk cycles per timeout unit (1 ms)
- TIMER_W, 24, timer width; must hold 48*UNIT_CYCLES
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  one-cycle pulse: evaluate `substate`
- substate  in  4  substate code, sampled with req
- num_lanes  in  $clog2(MAXLANES)+1  detected lane count
- os_hit  in  MAXLANES  per-lane level: checker reached os_required
- rx_elec_idle  in  1  receiver electrical idle
- abort  in  1  cancel evaluation in progress
- busy  out  1  evaluation in progress
- done  out  1  one-cycle result strobe
- pass  out  1  result, valid with done
- exit_to  out  4  next substate, valid with done, held until next done
- os_required  out  5  OS count loaded into checkers
- os_chk_rst  out  MAXLANES  active-high per-lane checker reset
- lane_mask  out  MAXLANES  active lanes of current evaluation
- disable_descrambler  out  1  descrambler bypass

## Operation
- Substate codes: 0 DETECT_QUIET, 1 DETECT_ACTIVE, 2 POLLING_ACTIVE, 3 POLLING_CONFIG, 4 CFG_LW_START, 5 CFG_LW_ACCEPT, 6 CFG_LN_WAIT, 7 CFG_LN_ACCEPT, 8 CFG_COMPLETE, 9 CFG_IDLE, 10 L0.
- Table, as os_required/timeout units/pass exit: 0: 0/12/1; 1: 0/0/2; 2: 8/24/3; 3: 8/48/4; 4: 2/24/5; 5: 2/24/6; 6: 2/2/7; 7: 2/24/8; 8: 8/24/9; 9: 8/2/10.
- Fail exit: DETECT_ACTIVE for DETECT_QUIET, DETECT_QUIET for all other substates.
- Codes ≥10: immediate fail, exit_to=0.
- lane_mask: the low num_lanes bits are set. Any count 1..MAXLANES is legal, not only powers of two. num_lanes=0 or >MAXLANES gives mask 0.
- FSM IDLE→ARM→COUNT→DONE→IDLE.
  - IDLE: req latches substate, mask and table entry → ARM.
  - ARM: checkers in reset, timer cleared → COUNT.
  - COUNT: evaluate every cycle → DONE.
- Pass condition:
  - DETECT_QUIET: !rx_elec_idle.
  - os_required=0: immediately true.
  - Otherwise: mask≠0 and (os_hit & mask)==mask.
- Priority in COUNT: abort > timeout > pass.
  - abort: IDLE, no done, exit_to unchanged.
  - timeout and pass in the same cycle: fail.
- req while busy is ignored. reset mid-evaluation returns to IDLE with all reset values.
- disable_descrambler=1 while busy with a latched substate <4, else 0.

## Timing
- Reset values: busy 0, done 0, pass 0, exit_to 0, os_required 0, os_chk_rst all 1, lane_mask 0, disable_descrambler 0, FSM IDLE.
- os_chk_rst:
  - All 1 in IDLE, ARM and DONE.
  - In COUNT: ~lane_mask, so unused lanes stay in reset.
- req at cycle t:
  - ARM at t+1; busy, lane_mask and os_required valid from t+1.
  - COUNT from t+2.
- Evaluation true in COUNT cycle c: done/pass at c+1, busy drops at c+2.
- Minimum req-to-done latency is 3 cycles (DETECT_ACTIVE).
- Timeout fires after timeout_units*UNIT_CYCLES COUNT cycles. Timer saturates and never wraps.
- Next req is accepted in the cycle after DONE.

## Structure
- Package rx_ltssm_pkg: substate codes, FSM state enum, and a table function (substate → os_required, timeout units, pass exit, fail exit).
- Sub-module rx_ltssm_timeout_timer contains the UNIT_CYCLES prescaler and unit counter (clear, enable, units in, expired out).

## Test plan
- req substate=2, num_lanes=4, os_hit=4'b1111 on the 2nd COUNT cycle → done,pass=1,exit_to=3 at req+4; os_chk_rst[15:4] stay 1 throughout.
- req substate=4, num_lanes=3, lane 2 never hits, UNIT_CYCLES=10 → done,pass=0,exit_to=0 after 240 COUNT cycles.
- req substate=0, rx_elec_idle=1 → timeout after 12 units, exit_to=1. Repeat with rx_elec_idle dropping in cycle 5 → pass, exit_to=1.
- substate=6, all hits arrive exactly on the timeout cycle → pass=0; abort mid-COUNT → no done, busy low next cycle, exit_to unchanged.
- req substate=12 → pass=0, exit_to=0; req substate=8 with num_lanes=0 → fail at timeout.
- reset asserted during COUNT → all outputs at reset values next cycle; a second req while busy produces exactly one done.
